// File: rtl/mux4_scan_sequencer.sv
// rtl/mux4_scan_sequencer.sv - steps a 4:1 mux through channels 0..3 and packs one sample per channel into a word
// Optional macro MUX4_SCAN_CONTINUOUS_EN: restart the scan after every word until iStop.
module mux4_scan_sequencer #(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic       iClk,
    input  logic       iReset,
    input  logic       iStart,
    input  logic       iStop,
    input  logic       iSample,
    output logic [1:0] oSelector,
    output logic [3:0] oData,
    output logic       oValid,
    output logic       oBusy
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DWELL - 1);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [2:0]       shadow;

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            state     <= IDLE;
            oSelector <= 2'd0;
            count     <= '0;
            shadow    <= 3'd0;
            oData     <= 4'd0;
            oValid    <= 1'b0;
            oBusy     <= 1'b0;
        end else begin
            oValid <= 1'b0;
            if (iStop) begin
                state     <= IDLE;
                oSelector <= 2'd0;
                count     <= '0;
                oBusy     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (iStart) begin
                            state     <= SCAN;
                            oSelector <= 2'd0;
                            count     <= '0;
                            oBusy     <= 1'b1;
                        end
                    end
                    SCAN: begin
                        // Only the final dwell cycle is sampled so the mux has settled.
                        if (count == LAST_COUNT) begin
                            count <= '0;
                            case (oSelector)
                                2'd0: begin
                                    shadow[0] <= iSample;
                                    oSelector <= 2'd1;
                                end
                                2'd1: begin
                                    shadow[1] <= iSample;
                                    oSelector <= 2'd2;
                                end
                                2'd2: begin
                                    shadow[2] <= iSample;
                                    oSelector <= 2'd3;
                                end
                                default: begin
                                    oData  <= {iSample, shadow};
                                    oValid <= 1'b1;
                                    state  <= DONE;
                                end
                            endcase
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                    DONE: begin
                        oSelector <= 2'd0;
                        count     <= '0;
`ifdef MUX4_SCAN_CONTINUOUS_EN
                        state     <= SCAN;
`else
                        state     <= IDLE;
                        oBusy     <= 1'b0;
`endif
                    end
                    default: begin
                        state     <= IDLE;
                        oSelector <= 2'd0;
                        count     <= '0;
                        oBusy     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mux4_scan_sequencer.sv
// tb/tb_mux4_scan_sequencer.sv - directed self-checking bench for mux4_scan_sequencer (DWELL=4 and DWELL=1)
module tb_mux4_scan_sequencer;

    logic clk;
    logic rst;

    logic       startA, stopA, sampleA, validA, busyA;
    logic [1:0] selA;
    logic [3:0] dataA, muxA;

    logic       startB, stopB, sampleB, validB, busyB;
    logic [1:0] selB;
    logic [3:0] dataB, muxB;

    int nChecks = 0;
    int nFails  = 0;

    assign sampleA = muxA[selA];
    assign sampleB = muxB[selB];

    mux4_scan_sequencer #(.DWELL(4), .CNT_W(8)) dutA (
        .iClk(clk), .iReset(rst), .iStart(startA), .iStop(stopA), .iSample(sampleA),
        .oSelector(selA), .oData(dataA), .oValid(validA), .oBusy(busyA)
    );

    mux4_scan_sequencer #(.DWELL(1), .CNT_W(8)) dutB (
        .iClk(clk), .iReset(rst), .iStart(startB), .iStop(stopB), .iSample(sampleB),
        .oSelector(selB), .oData(dataB), .oValid(validB), .oBusy(busyB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        rst = 1'b1;
        startA = 0; stopA = 0; muxA = 4'd0;
        startB = 0; stopB = 0; muxB = 4'd0;
        @(negedge clk);
        @(negedge clk);
        nChecks++; if (selA !== 2'd0) begin nFails++; $display("FAIL reset_sel got %0d want 0", selA); end
        nChecks++; if (dataA !== 4'd0) begin nFails++; $display("FAIL reset_data got %b want 0000", dataA); end
        nChecks++; if (validA !== 1'b0) begin nFails++; $display("FAIL reset_valid got %b want 0", validA); end
        nChecks++; if (busyA !== 1'b0) begin nFails++; $display("FAIL reset_busy got %b want 0", busyA); end
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            nChecks++; if (validA !== 1'b0 || busyA !== 1'b0) begin
                nFails++; $display("FAIL reset_idle cycle %0d valid %b busy %b want 0 0", k, validA, busyA);
            end
        end
    endtask

    task automatic test_basic;
        logic [1:0] expSel;
        muxA = 4'b1010;
        @(negedge clk); startA = 1'b1;
        @(negedge clk); startA = 1'b0;
        nChecks++; if (selA !== 2'd0 || busyA !== 1'b1) begin
            nFails++; $display("FAIL basic_start sel %0d busy %b want 0 1", selA, busyA);
        end
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            if (k <= 15) begin
                expSel = 2'(k / 4);
                nChecks++; if (selA !== expSel) begin
                    nFails++; $display("FAIL basic_sel k=%0d got %0d want %0d", k, selA, expSel);
                end
            end
            nChecks++; if (validA !== (k == 16)) begin
                nFails++; $display("FAIL basic_valid k=%0d got %b want %b", k, validA, (k == 16));
            end
            if (k == 16) begin
                nChecks++; if (dataA !== 4'b1010) begin
                    nFails++; $display("FAIL basic_data got %b want 1010", dataA);
                end
            end
            if (k == 17) begin
                nChecks++; if (busyA !== 1'b0) begin
                    nFails++; $display("FAIL basic_busy_after got %b want 0", busyA);
                end
            end
        end
    endtask

    task automatic test_stop;
        muxA = 4'b0101;
        @(negedge clk); startA = 1'b1;
        @(negedge clk); startA = 1'b0;
        for (int k = 1; k <= 9; k++) @(negedge clk);
        stopA = 1'b1;
        @(negedge clk);
        stopA = 1'b0;
        nChecks++; if (busyA !== 1'b0 || selA !== 2'd0 || validA !== 1'b0) begin
            nFails++; $display("FAIL stop_exit busy %b sel %0d valid %b want 0 0 0", busyA, selA, validA);
        end
        nChecks++; if (dataA !== 4'b1010) begin
            nFails++; $display("FAIL stop_data_kept got %b want 1010", dataA);
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            nChecks++; if (validA !== 1'b0) begin
                nFails++; $display("FAIL stop_no_valid cycle %0d got %b want 0", k, validA);
            end
        end
        startA = 1'b1; stopA = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            nChecks++; if (busyA !== 1'b0) begin
                nFails++; $display("FAIL stop_priority cycle %0d busy %b want 0", k, busyA);
            end
        end
        startA = 1'b0; stopA = 1'b0;
        @(negedge clk);
        nChecks++; if (busyA !== 1'b0 || dataA !== 4'b1010) begin
            nFails++; $display("FAIL stop_priority_after busy %b data %b want 0 1010", busyA, dataA);
        end
    endtask

    task automatic test_async_reset;
        muxA = 4'b1111;
        @(negedge clk); startA = 1'b1;
        @(negedge clk); startA = 1'b0;
        for (int k = 1; k <= 6; k++) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        nChecks++; if (selA !== 2'd0 || dataA !== 4'd0 || validA !== 1'b0 || busyA !== 1'b0) begin
            nFails++; $display("FAIL async_reset sel %0d data %b valid %b busy %b want all 0", selA, dataA, validA, busyA);
        end
        @(negedge clk); rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            nChecks++; if (validA !== 1'b0 || busyA !== 1'b0) begin
                nFails++; $display("FAIL async_reset_idle cycle %0d valid %b busy %b want 0 0", k, validA, busyA);
            end
        end
    endtask

    task automatic test_mid_dwell;
        muxA = 4'b0001;
        @(negedge clk); startA = 1'b1;
        @(negedge clk); startA = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 2)  muxA[3] = 1'b1;
            if (k == 5)  muxA[1] = 1'b1;
            if (k == 11) muxA[2] = 1'b1;
            if (k == 13) muxA[3] = 1'b0;
        end
        nChecks++; if (validA !== 1'b1 || dataA !== 4'b0111) begin
            nFails++; $display("FAIL mid_dwell valid %b data %b want 1 0111", validA, dataA);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int nValid;
        logic prevValid;
        nValid = 0;
        prevValid = 1'b0;
        muxA = 4'b1100;
        @(negedge clk); startA = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            nChecks++; if (validA !== (k == 16 || k == 34)) begin
                nFails++; $display("FAIL b2b_valid k=%0d got %b want %b", k, validA, (k == 16 || k == 34));
            end
            if (validA === 1'b1) begin
                nValid++;
                nChecks++; if (prevValid === 1'b1) begin
                    nFails++; $display("FAIL b2b_consecutive k=%0d got 1 1 want not both", k);
                end
            end
            prevValid = validA;
        end
        startA = 1'b0;
        nChecks++; if (nValid != 2) begin
            nFails++; $display("FAIL b2b_count got %0d want 2", nValid);
        end
        for (int k = 0; k < 20; k++) @(negedge clk);
        nChecks++; if (busyA !== 1'b0 || dataA !== 4'b1100) begin
            nFails++; $display("FAIL b2b_drain busy %b data %b want 0 1100", busyA, dataA);
        end
    endtask

    task automatic test_dwell1;
        muxB = 4'b0110;
        @(negedge clk); startB = 1'b1;
        @(negedge clk); startB = 1'b0;
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) @(negedge clk);
            if (k <= 3) begin
                nChecks++; if (selB !== 2'(k)) begin
                    nFails++; $display("FAIL dwell1_sel k=%0d got %0d want %0d", k, selB, k);
                end
            end
            nChecks++; if (validB !== (k == 4)) begin
                nFails++; $display("FAIL dwell1_valid k=%0d got %b want %b", k, validB, (k == 4));
            end
            if (k == 4) begin
                nChecks++; if (dataB !== 4'b0110) begin
                    nFails++; $display("FAIL dwell1_data got %b want 0110", dataB);
                end
            end
            if (k == 5) begin
                nChecks++; if (busyB !== 1'b0) begin
                    nFails++; $display("FAIL dwell1_busy_after got %b want 0", busyB);
                end
            end
        end
    endtask

`ifdef MUX4_SCAN_CONTINUOUS_EN
    task automatic test_scan_mode;
        logic [3:0] expData;
        expData = 4'hF;
        muxA = 4'hF;
        @(negedge clk); startA = 1'b1;
        @(negedge clk); startA = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            nChecks++; if (validA !== (k == 16 || k == 33 || k == 50)) begin
                nFails++; $display("FAIL cont_valid k=%0d got %b want %b", k, validA, (k == 16 || k == 33 || k == 50));
            end
            nChecks++; if (busyA !== 1'b1) begin
                nFails++; $display("FAIL cont_busy k=%0d got %b want 1", k, busyA);
            end
            if (validA === 1'b1) begin
                nChecks++; if (dataA !== expData) begin
                    nFails++; $display("FAIL cont_data k=%0d got %h want %h", k, dataA, expData);
                end
                expData = ~expData;
                muxA = expData;
            end
        end
        stopA = 1'b1;
        @(negedge clk);
        stopA = 1'b0;
        nChecks++; if (busyA !== 1'b0) begin
            nFails++; $display("FAIL cont_stop busy %b want 0", busyA);
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            nChecks++; if (validA !== 1'b0 || busyA !== 1'b0) begin
                nFails++; $display("FAIL cont_halted cycle %0d valid %b busy %b want 0 0", k, validA, busyA);
            end
        end
    endtask
`else
    task automatic test_scan_mode;
        muxA = 4'hF;
        @(negedge clk); startA = 1'b1;
        @(negedge clk); startA = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            nChecks++; if (validA !== (k == 16)) begin
                nFails++; $display("FAIL single_valid k=%0d got %b want %b", k, validA, (k == 16));
            end
            if (k >= 17) begin
                nChecks++; if (busyA !== 1'b0) begin
                    nFails++; $display("FAIL single_busy k=%0d got %b want 0", k, busyA);
                end
            end
        end
        nChecks++; if (dataA !== 4'hF) begin
            nFails++; $display("FAIL single_data got %h want f", dataA);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_stop();
        test_async_reset();
        test_mid_dwell();
        test_back_to_back();
        test_dwell1();
        test_scan_mode();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
